// File: rtl/fir_filter.sv
// -----------------------------------------------------------------------------
// fir_filter -- 16-tap symmetric low-pass FIR for signed 8-bit audio samples.
//
// Datapath (two pipeline stages after the sample strobe):
//   stage 1 : on valid_in the delay line shifts in audio_in. The 16 products
//             h[k]*x[k] of the *updated* delay line are registered on the
//             same clock edge.
//   stage 2 : the products are summed, optionally rounded, arithmetically
//             shifted right by 7 and saturated to 8 bits. The result is
//             registered into filtered_audio together with the data_ready
//             strobe.
//   A strobe sampled on cycle N therefore appears on cycle N+2. Back-to-back
//   strobes stream through with no stall.
//
// Configuration macro:
//   FIR_ROUND_EN : when defined, 64 is added before the >>>7 (round half up).
//                  When undefined, the shift truncates toward -infinity.
//
// Ports:
//   clk_in         : system clock, rising-edge active
//   rst_in         : asynchronous active-high reset (clears all state)
//   audio_in       : signed 8-bit input sample, qualified by valid_in
//   valid_in       : single-cycle input strobe
//   filtered_audio : signed 8-bit filtered sample, held between updates
//   data_ready     : single-cycle strobe marking a new filtered_audio value
// -----------------------------------------------------------------------------
module fir_filter #(
    parameter int NUM_TAPS  = 16,
    parameter int ACC_WIDTH = 20
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic signed [7:0] audio_in,
    input  logic              valid_in,
    output logic signed [7:0] filtered_audio,
    output logic              data_ready
);

    // Saturation bounds expressed at accumulator width so that the compares
    // are width-matched and signed.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(127);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-128);
`ifdef FIR_ROUND_EN
    localparam logic signed [ACC_WIDTH-1:0] ROUND_OFS = ACC_WIDTH'(64);
`endif

    // Fixed low-pass coefficients. They sum to 128, so a >>>7 of the
    // accumulator gives unity DC gain.
    function automatic logic signed [7:0] coef(input int k);
        logic signed [7:0] c;
        case (k)
            0:       c = 8'sd1;
            1:       c = 8'sd2;
            2:       c = 8'sd4;
            3:       c = 8'sd6;
            4:       c = 8'sd9;
            5:       c = 8'sd12;
            6:       c = 8'sd14;
            7:       c = 8'sd16;
            8:       c = 8'sd16;
            9:       c = 8'sd14;
            10:      c = 8'sd12;
            11:      c = 8'sd9;
            12:      c = 8'sd6;
            13:      c = 8'sd4;
            14:      c = 8'sd2;
            15:      c = 8'sd1;
            default: c = 8'sd0;
        endcase
        return c;
    endfunction

    // Clamp an accumulator-width value into the signed 8-bit output range.
    function automatic logic signed [7:0] sat8(input logic signed [ACC_WIDTH-1:0] v);
        logic signed [7:0] r;
        if (v > SAT_MAX) begin
            r = 8'sh7F;
        end else if (v < SAT_MIN) begin
            r = 8'sh80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    logic signed [7:0]           taps_r      [NUM_TAPS];
    logic signed [7:0]           taps_next_s [NUM_TAPS];
    logic signed [ACC_WIDTH-1:0] prod_s      [NUM_TAPS];
    logic signed [ACC_WIDTH-1:0] prod_r      [NUM_TAPS];
    logic                        valid1_r;
    logic signed [ACC_WIDTH-1:0] acc_s;
    logic signed [ACC_WIDTH-1:0] rounded_s;
    logic signed [ACC_WIDTH-1:0] shifted_s;

    // Delay line contents as they will be after this cycle's shift.
    always_comb begin
        taps_next_s[0] = audio_in;
        for (int k = 1; k < NUM_TAPS; k++) begin
            taps_next_s[k] = taps_r[k-1];
        end
    end

    // Products of the updated delay line; stage 1 registers these so the
    // output reflects the sample just accepted.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            prod_s[k] = ACC_WIDTH'(taps_next_s[k]) * ACC_WIDTH'(coef(k));
        end
    end

    // Delay line: shifts only on an accepted sample.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                taps_r[k] <= 8'sd0;
            end
        end else if (valid_in) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                taps_r[k] <= taps_next_s[k];
            end
        end else begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                taps_r[k] <= taps_r[k];
            end
        end
    end

    // Stage 1 pipeline register: products plus the stage valid flag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                prod_r[k] <= '0;
            end
            valid1_r <= 1'b0;
        end else begin
            if (valid_in) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    prod_r[k] <= prod_s[k];
                end
            end else begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    prod_r[k] <= prod_r[k];
                end
            end
            valid1_r <= valid_in;
        end
    end

    // Adder tree, optional rounding offset and arithmetic scale-down.
    // |y| <= 128*128, so ACC_WIDTH = 20 cannot overflow.
    always_comb begin
        acc_s = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            acc_s = acc_s + prod_r[k];
        end
`ifdef FIR_ROUND_EN
        rounded_s = acc_s + ROUND_OFS;
`else
        rounded_s = acc_s;
`endif
        shifted_s = rounded_s >>> 7;
    end

    // Stage 2 output register: update only when stage 1 holds a sample,
    // otherwise hold the last filtered value.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            filtered_audio <= 8'sd0;
            data_ready     <= 1'b0;
        end else begin
            if (valid1_r) begin
                filtered_audio <= sat8(shifted_s);
            end else begin
                filtered_audio <= filtered_audio;
            end
            data_ready <= valid1_r;
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// -----------------------------------------------------------------------------
// tb_fir_filter -- self-checking bench for fir_filter.
// Inputs are driven and outputs sampled on the falling clock edge. A
// behavioural model (history array + plain integer arithmetic) predicts every
// output value and the cycle it must appear on.
// -----------------------------------------------------------------------------
module tb_fir_filter;

    logic              clk_in;
    logic              rst_in;
    logic signed [7:0] audio_in;
    logic              valid_in;
    logic signed [7:0] filtered_audio;
    logic              data_ready;

    fir_filter #(.NUM_TAPS(16), .ACC_WIDTH(20)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .audio_in       (audio_in),
        .valid_in       (valid_in),
        .filtered_audio (filtered_audio),
        .data_ready     (data_ready)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic signed [7:0] val;
        int                due;
    } exp_t;

    typedef struct {
        logic signed [7:0] din;
        logic signed [7:0] dout;
    } vec_t;

    int                n_tests = 0;
    int                n_fail  = 0;
    int                cyc     = 0;
    int                rdy_cnt = 0;
    int                last_rdy_cyc = 0;
    bit                sq_mode = 1'b0;
    logic signed [7:0] last_out = 8'sd0;
    exp_t              exp_q[$];
    int                hist[16];
    int                h[16] = '{1, 2, 4, 6, 9, 12, 14, 16, 16, 14, 12, 9, 6, 4, 2, 1};
    vec_t              vecs[16];

    function automatic int floor_div128(input int v);
        if (v >= 0) return v / 128;
        else        return -((-v + 127) / 128);
    endfunction

    // Model: accept a sample, compute the filter output from the spec rules.
    task automatic model_push(input logic signed [7:0] s);
        int   y;
        int   q;
        exp_t e;
        for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'(s);
        y = 0;
        for (int k = 0; k < 16; k++) y += h[k] * hist[k];
`ifdef FIR_ROUND_EN
        q = floor_div128(y + 64);
`else
        q = floor_div128(y);
`endif
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        e.val = 8'(q);
        e.due = cyc + 2;
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        if (!rst_in) begin
            if (data_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ready cyc=%0d: got data_ready=1 value=%0d, required no output",
                             cyc, filtered_audio);
                end else begin
                    e = exp_q.pop_front();
                    if (e.due != cyc || filtered_audio !== e.val) begin
                        n_fail++;
                        $display("FAIL output cyc=%0d: got %0d, required %0d at cyc %0d",
                                 cyc, filtered_audio, e.val, e.due);
                    end
                end
                if (sq_mode) begin
                    n_tests++;
                    if ($signed(filtered_audio) > 0 || $signed(filtered_audio) < -1) begin
                        n_fail++;
                        $display("FAIL square_range cyc=%0d: got %0d, required -1..0", cyc, filtered_audio);
                    end
                end
                last_out     = filtered_audio;
                rdy_cnt++;
                last_rdy_cyc = cyc;
            end else begin
                n_tests++;
                if (filtered_audio !== last_out) begin
                    n_fail++;
                    $display("FAIL hold cyc=%0d: got %0d, required %0d", cyc, filtered_audio, last_out);
                end
                n_tests++;
                if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                    n_fail++;
                    $display("FAIL missing_ready cyc=%0d: got data_ready=0, required value %0d due cyc %0d",
                             cyc, exp_q[0].val, exp_q[0].due);
                    void'(exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        cyc++;
        @(negedge clk_in);
        monitor();
    endtask

    task automatic send(input logic signed [7:0] s);
        audio_in = s;
        valid_in = 1'b1;
        model_push(s);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_in = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 16; k++) hist[k] = 0;
        last_out = 8'sd0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            cyc++;
            @(negedge clk_in);
            n_tests++;
            if (filtered_audio !== 8'sd0 || data_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state cyc=%0d: got out=%0d rdy=%0b, required 0/0",
                         cyc, filtered_audio, data_ready);
            end
        end
        rst_in = 1'b0;
    endtask

    task automatic check_val(input string name, input logic signed [7:0] req);
        n_tests++;
        if (filtered_audio !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0d, required %0d", name, cyc, filtered_audio, req);
        end
    endtask

    task automatic run_impulse(input string name);
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].din);
            tick();
            check_val(name, vecs[i].dout);
        end
    endtask

    initial begin
        int k0;
        int cnt0;
        logic signed [7:0] imp_out[16];

        rst_in   = 1'b1;
        valid_in = 1'b0;
        audio_in = 8'sd0;

`ifdef FIR_ROUND_EN
        imp_out = '{8'sd1, 8'sd2, 8'sd4, 8'sd6, 8'sd9, 8'sd12, 8'sd14, 8'sd16,
                    8'sd16, 8'sd14, 8'sd12, 8'sd9, 8'sd6, 8'sd4, 8'sd2, 8'sd1};
`else
        imp_out = '{8'sd0, 8'sd1, 8'sd3, 8'sd5, 8'sd8, 8'sd11, 8'sd13, 8'sd15,
                    8'sd15, 8'sd13, 8'sd11, 8'sd8, 8'sd5, 8'sd3, 8'sd1, 8'sd0};
`endif
        for (int i = 0; i < 16; i++) begin
            vecs[i].din  = (i == 0) ? 8'sd127 : 8'sd0;
            vecs[i].dout = imp_out[i];
        end

        // Reset with no strobes: outputs stay zero during and after.
        do_reset(3);
        repeat (4) tick();
        check_val("post_reset_out", 8'sd0);

        // Impulse response from zero state.
        run_impulse("impulse");

        // DC -1 with one strobe every 16 cycles, then DC +127.
        for (int i = 0; i < 20; i++) begin
            send(8'shFF);
            repeat (15) tick();
        end
        check_val("dc_minus1", 8'shFF);
        for (int i = 0; i < 20; i++) begin
            send(8'sd127);
            repeat (15) tick();
        end
        check_val("dc_127", 8'sd127);

        // Three back-to-back strobes: pulses on k0+2, k0+3, k0+4.
        k0   = cyc;
        cnt0 = rdy_cnt;
        for (int j = 0; j < 3; j++) begin
            audio_in = 8'(j * 40 - 50);
            valid_in = 1'b1;
            model_push(audio_in);
            tick();
        end
        valid_in = 1'b0;
        repeat (4) tick();
        n_tests++;
        if (rdy_cnt - cnt0 != 3 || last_rdy_cyc != k0 + 4) begin
            n_fail++;
            $display("FAIL burst_latency: got %0d pulses last at cyc %0d, required 3 ending cyc %0d",
                     rdy_cnt - cnt0, last_rdy_cyc, k0 + 4);
        end

        // Reset one cycle after a strobe: the in-flight sample is discarded.
        send(8'sd50);
        do_reset(2);
        cnt0 = rdy_cnt;
        repeat (4) tick();
        n_tests++;
        if (rdy_cnt != cnt0) begin
            n_fail++;
            $display("FAIL mid_reset_ready: got %0d pulses, required 0", rdy_cnt - cnt0);
        end
        run_impulse("impulse_after_reset");

        // Randomized samples with random gaps.
        for (int i = 0; i < 300; i++) begin
            send(8'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (4) tick();

        // Square wave from a clean state.
        do_reset(2);
        sq_mode = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send(((i / 64) % 2 == 0) ? 8'shFF : 8'sh00);
        end
        repeat (4) tick();
        sq_mode = 1'b0;

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d outputs still pending, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_filter.md
FIR_FILTER -- requirements
Module: fir_filter

Interface
REQ-001 SHALL declare parameter NUM_TAPS, default 16, the number of filter taps (fixed at 16; other values unsupported).
REQ-002 SHALL declare parameter ACC_WIDTH, default 20, the signed accumulator width in bits.
REQ-003 SHALL have port clk_in, input, 1, the single system clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port audio_in, input, 8, signed two's-complement input sample.
REQ-006 SHALL have port valid_in, input, 1, single-cycle strobe; audio_in is valid when it is high.
REQ-007 SHALL have port filtered_audio, output, 8, signed two's-complement filtered sample, held between updates.
REQ-008 SHALL have port data_ready, output, 1, single-cycle strobe marking a new filtered_audio value.

Function
REQ-009 SHALL keep a 16-entry signed 8-bit delay line x[0..15]; on valid_in, x[0]<=audio_in and x[k]<=x[k-1].
REQ-010 SHALL leave the delay line unchanged in cycles with valid_in low.
REQ-011 SHALL use fixed signed 8-bit coefficients h[0..15] = 1,2,4,6,9,12,14,16,16,14,12,9,6,4,2,1 (sum 128, unity DC gain).
REQ-012 SHALL compute y = sum over k of h[k]*x[k] in ACC_WIDTH-bit signed arithmetic, with no overflow possible.
REQ-013 SHALL form filtered_audio from y arithmetically shifted right by 7 (see REQ-021/022), then saturated to [-128,127].
REQ-014 SHALL pipeline the filter in 2 stages: stage 1 registers the 16 products of the updated delay line; stage 2 registers the sum, shift and saturation.
REQ-015 SHALL make filtered_audio and data_ready valid on cycle N+2 when valid_in is high on cycle N.
REQ-016 SHALL hold data_ready high for exactly one cycle per accepted valid_in.
REQ-017 SHALL accept valid_in on every cycle, including back-to-back cycles; each strobe yields exactly one output, in order, with no stall and no ready signal.
REQ-018 SHALL keep filtered_audio at its last value when no data_ready is issued.

Reset
REQ-019 SHALL asynchronously clear, while rst_in is high: the delay line, the pipeline registers, filtered_audio (0) and data_ready (0).
REQ-020 SHALL, on reset asserted mid-operation, discard all in-flight samples; no data_ready occurs for any valid_in accepted before reset, and valid_in is ignored while rst_in is high.

Configuration
REQ-021 SHALL, when macro FIR_ROUND_EN is defined, add 64 to y before the 7-bit arithmetic shift (round half up).
REQ-022 SHALL, when FIR_ROUND_EN is undefined, shift y without the offset (floor/truncate toward negative infinity).

Verification
REQ-023 SHALL cover reset: pulse rst_in with no valid_in -> filtered_audio=0 and data_ready=0 throughout.
REQ-024 SHALL cover impulse: one sample 127 then 15 zeros (each on valid_in) -> outputs 0,1,3,5,8,11,13,15,15,13,11,8,5,3,1,0 without FIR_ROUND_EN, and 1,2,4,6,9,12,14,16,16,14,12,9,6,4,2,1 with FIR_ROUND_EN.
REQ-025 SHALL cover DC input: constant 8'hFF, valid_in every 16 cycles, for at least 16 strobes -> output settles at -1 (8'hFF); constant 127 -> output settles at 127.
REQ-026 SHALL cover latency and back-to-back input: valid_in on 3 consecutive cycles -> 3 data_ready pulses on the 3 consecutive cycles starting 2 cycles after the first strobe.
REQ-027 SHALL cover mid-operation reset: rst_in asserted 1 cycle after valid_in -> no data_ready follows, and the next impulse reproduces the sequence in REQ-024 from a zero state.
REQ-028 SHALL cover square-wave input: 8'hFF/8'h00 toggling every 64 strobes -> output stays within [-1,0], with no glitches outside that range.
